bancoreg_multi: RTL and testbench
=================================

# bancoreg_multi

Parametrised successor of the processor register file: NREGS registers of XLEN bits, NREAD asynchronous read ports and one synchronous write port. It adds an asynchronous clear and an integrated scoreboard of per-register pending bits, so the issue stage can detect RAW and WAW hazards against in-flight writebacks. It sits between decode/issue, which reads operands and marks destinations, and writeback, which writes results and clears pending bits.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers (power of two, ≥2); register 0 hardwired to zero.
- NREAD, 2: number of read ports (≥1).
- AW (localparam), $clog2(NREGS): address width.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- write_enable  input  1  writeback strobe.
- write  input  AW  writeback destination address.
- data  input  XLEN  writeback value.
- regaddr  input  NREAD*AW  read addresses; port i at bits [i*AW +: AW].
- read  output  NREAD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- issue_enable  input  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  input  AW  destination of the issuing instruction.
- busy  output  NREAD  busy[i] = register at regaddr port i has a pending write.
- stall  output  1  hazard present; the issue stage must hold.

## Operation
- Storage mem[NREGS]; pending[NREGS] bits.
- Reset (rst_n=0): all mem=0, all pending=0, effective immediately and independent of clk. Outputs during reset: read=0, busy=0, stall=0.
- Write: on a rising edge with write_enable=1 and write≠0, mem[write]←data and pending[write]←0. A write to address 0 is ignored.
- Read (combinational): port i returns 0 if regaddr_i=0, else mem[regaddr_i]. Ports are independent; any ports may share an address.
- Issue: on a rising edge with issue_enable=1, issue_rd≠0 and stall=0, pending[issue_rd]←1. An issue while stall=1 or to address 0 has no effect.
- Simultaneous write and issue to the same register on one edge: pending ends at 1 (issue wins); mem still takes data.
- busy[i] = pending_eff[regaddr_i], forced to 0 when regaddr_i=0.
- stall = OR(busy) | (issue_enable & pending_eff[issue_rd]), where the second term is the WAW check.
- pending_eff is defined under Configuration.
- Reset asserted mid-operation discards all pending state; writes already in flight after reset release are accepted normally.

## Timing
- Read latency 0 cycles from regaddr (combinational path).
- A written value is visible on read in the cycle after the write edge (without bypass).
- pending set at the issue edge; busy/stall reflect it from the next cycle.
- Minimum issue→clear→reissue of the same register: 1 cycle each, with no bubble required by this block.

## Configuration
- BANCOREG_BYPASS_EN defined: same-cycle forwarding. If write_enable=1, write≠0 and write=regaddr_i, then read port i = data combinationally. pending_eff[r] = pending[r] & ~(write_enable & write==r), so a register being written this cycle raises no busy and no stall.
- Not defined: read returns mem contents only, and pending_eff = pending. A consumer sees busy until the cycle after writeback, which costs one extra stall cycle per dependency.

## Structure
- Package bancoreg_pkg:
  - default XLEN/NREGS constants;
  - ZERO_REG = '0;
  - typedef for the register-address type.
- Sub-module bancoreg_scoreboard: holds pending[], implements set/clear priority and pending_eff, and outputs busy and stall.
- The top level holds storage, read muxing and bypass.

## Test plan
- Reset then read all ports at every address: read=0, busy=0, stall=0. Assert rst_n=0 mid-run after writing 0xDEADBEEF to x5: read of x5 returns 0 immediately.
- Write 0x12345678 to x0, then read x0: read=0. Issue to x0: busy stays 0.
- Issue x7; next cycle regaddr port0=7: busy[0]=1, stall=1. Write x7=0xA5A5A5A5:
  - with BYPASS_EN, in the same cycle read=0xA5A5A5A5 and stall=0;
  - without it, stall clears and read=0xA5A5A5A5 one cycle later.
- Issue x3, then issue_enable with issue_rd=3 while x3 is still pending: stall=1 (WAW) and the issue is not recorded. After writeback of x3 the re-issue is accepted.
- Same edge: write x9=0x1 and issue x9: mem[9]=1 and pending[9]=1. Next cycle busy=1 for port reading x9.
- NREAD=3, XLEN=64, NREGS=16: all three ports read x15=0xFFFF_0000_FFFF_0000 concurrently and return identical values.

Source files
------------

// File: rtl/bancoreg_pkg.sv
// Shared constants and types for the multi-port register file with hazard scoreboard.
package bancoreg_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/bancoreg_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, issue wins on a tie.
// With BANCOREG_BYPASS_EN, a register being written this cycle is not seen as pending.
module bancoreg_scoreboard #(
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write_enable,
    input  logic [AW-1:0]      write,
    input  logic               issue_enable,
    input  logic [AW-1:0]      issue_rd,
    input  logic [NREAD*AW-1:0] regaddr,
    output logic [NREAD-1:0]   busy,
    output logic               stall
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] pending_eff_s;
    logic [NREGS-1:0] wr_hit_s;
    logic [NREGS-1:0] iss_hit_s;
    logic [AW-1:0]    addr_s;

    // One-hot of the register cleared by writeback; x0 is never tracked
    always_comb begin
        wr_hit_s = '0;
        if (write_enable && (write != '0)) begin
            wr_hit_s[write] = 1'b1;
        end else begin
            wr_hit_s = '0;
        end
    end

`ifdef BANCOREG_BYPASS_EN
    assign pending_eff_s = pending_q & ~wr_hit_s;
`else
    assign pending_eff_s = pending_q;
`endif

    // RAW check per read port, plus WAW check against the issuing destination
    always_comb begin
        busy   = '0;
        addr_s = '0;
        for (int i = 0; i < NREAD; i++) begin
            addr_s = regaddr[i*AW +: AW];
            if (addr_s != '0) begin
                busy[i] = pending_eff_s[addr_s];
            end else begin
                busy[i] = 1'b0;
            end
        end
        stall = (|busy) | (issue_enable & pending_eff_s[issue_rd]);
    end

    // Issue only lands when the issue stage is not being held
    always_comb begin
        iss_hit_s = '0;
        if (issue_enable && (issue_rd != '0) && !stall) begin
            iss_hit_s[issue_rd] = 1'b1;
        end else begin
            iss_hit_s = '0;
        end
        pending_d = (pending_q & ~wr_hit_s) | iss_hit_s;
    end

    // Pending state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/bancoreg_multi.sv
// NREGS x XLEN register file, NREAD async read ports, one write port, pending-bit scoreboard.
// Optional same-cycle write-to-read forwarding when BANCOREG_BYPASS_EN is defined.
module bancoreg_multi
    import bancoreg_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [AW-1:0]         write,
    input  logic [XLEN-1:0]       data,
    input  logic [NREAD*AW-1:0]   regaddr,
    output logic [NREAD*XLEN-1:0] read,
    input  logic                  issue_enable,
    input  logic [AW-1:0]         issue_rd,
    output logic [NREAD-1:0]      busy,
    output logic                  stall
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rd_s;
    logic            byp_hit_s;

    // Storage; x0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (write_enable && (write != '0)) begin
            mem_q[write] <= data;
        end
    end

    // Read muxing; forwarding is gated by reset so read stays 0 while held in reset
    always_comb begin
        read      = '0;
        ra_s      = '0;
        rd_s      = '0;
        byp_hit_s = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            ra_s = regaddr[i*AW +: AW];
`ifdef BANCOREG_BYPASS_EN
            byp_hit_s = rst_n & write_enable & (write == ra_s) & (ra_s != '0);
`else
            byp_hit_s = 1'b0;
`endif
            if (byp_hit_s) begin
                rd_s = data;
            end else if (ra_s != '0) begin
                rd_s = mem_q[ra_s];
            end else begin
                rd_s = '0;
            end
            read[i*XLEN +: XLEN] = rd_s;
        end
    end

    bancoreg_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .write        (write),
        .issue_enable (issue_enable),
        .issue_rd     (issue_rd),
        .regaddr      (regaddr),
        .busy         (busy),
        .stall        (stall)
    );

endmodule

// File: tb/tb_bancoreg_multi.sv
// Bench for bancoreg_multi: default 32x32x2 instance plus a 16x64x3 instance.
module tb_bancoreg_multi;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we;
    logic [4:0]   wr;
    logic [31:0]  wdata;
    logic [9:0]   ra;
    logic [63:0]  rd;
    logic         ie;
    logic [4:0]   ird;
    logic [1:0]   busy;
    logic         stall;

    logic         we3;
    logic [3:0]   wr3;
    logic [63:0]  wdata3;
    logic [11:0]  ra3;
    logic [191:0] rd3;
    logic         ie3;
    logic [3:0]   ird3;
    logic [2:0]   busy3;
    logic         stall3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    bancoreg_multi u_dut (
        .clk(clk), .rst_n(rst_n), .write_enable(we), .write(wr), .data(wdata),
        .regaddr(ra), .read(rd), .issue_enable(ie), .issue_rd(ird),
        .busy(busy), .stall(stall)
    );

    bancoreg_multi #(.XLEN(64), .NREGS(16), .NREAD(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .write_enable(we3), .write(wr3), .data(wdata3),
        .regaddr(ra3), .read(rd3), .issue_enable(ie3), .issue_rd(ird3),
        .busy(busy3), .stall(stall3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            0:       return {32'h0, rd[31:0]};
            1:       return {32'h0, rd[63:32]};
            2:       return {62'h0, busy};
            3:       return {63'h0, stall};
            4:       return rd3[63:0];
            5:       return rd3[127:64];
            6:       return rd3[191:128];
            7:       return {61'h0, busy3};
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int kind, input logic [63:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wr = 5'd0; wdata = 32'h0; ra = 10'h0; ie = 1'b0; ird = 5'd0;
        we3 = 1'b0; wr3 = 4'd0; wdata3 = 64'h0; ra3 = 12'h0; ie3 = 1'b0; ird3 = 4'd0;

        // Outputs while held in reset
        #1;
        set_ra(5'd5, 5'd31);
        expect_v("rst_rd0", 0, 64'h0);
        expect_v("rst_rd1", 1, 64'h0);
        expect_v("rst_busy", 2, 64'h0);
        expect_v("rst_stall", 3, 64'h0);
        sample();
        #1 rst_n = 1'b1;
        tick();

        // Every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            expect_v("init_rd0", 0, 64'h0);
            expect_v("init_rd1", 1, 64'h0);
            expect_v("init_busy", 2, 64'h0);
            expect_v("init_stall", 3, 64'h0);
            sample();
        end

        // Write x5 then async reset clears it immediately
        tick();
        we = 1'b1; wr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        set_ra(5'd5, 5'd0);
        expect_v("x5_written", 0, 64'hDEADBEEF);
        sample();
        rst_n = 1'b0;
        expect_v("x5_async_rst", 0, 64'h0);
        sample();
        rst_n = 1'b1;
        tick();

        // Writes and issues to x0 are ignored
        we = 1'b1; wr = 5'd0; wdata = 32'h12345678;
        tick();
        we = 1'b0;
        set_ra(5'd0, 5'd0);
        expect_v("x0_read", 0, 64'h0);
        sample();
        ie = 1'b1; ird = 5'd0;
        expect_v("x0_issue_stall", 3, 64'h0);
        sample();
        tick();
        ie = 1'b0;
        expect_v("x0_busy", 2, 64'h0);
        expect_v("x0_stall", 3, 64'h0);
        sample();

        // RAW on x7 resolved by writeback
        ie = 1'b1; ird = 5'd7;
        expect_v("x7_issue_free", 3, 64'h0);
        sample();
        tick();
        ie = 1'b0;
        set_ra(5'd7, 5'd0);
        expect_v("x7_busy", 2, 64'h1);
        expect_v("x7_stall", 3, 64'h1);
        sample();
        we = 1'b1; wr = 5'd7; wdata = 32'hA5A5A5A5;
`ifdef BANCOREG_BYPASS_EN
        expect_v("x7_wb_rd", 0, 64'hA5A5A5A5);
        expect_v("x7_wb_busy", 2, 64'h0);
        expect_v("x7_wb_stall", 3, 64'h0);
`else
        expect_v("x7_wb_rd", 0, 64'h0);
        expect_v("x7_wb_busy", 2, 64'h1);
        expect_v("x7_wb_stall", 3, 64'h1);
`endif
        sample();
        tick();
        we = 1'b0;
        expect_v("x7_after_rd", 0, 64'hA5A5A5A5);
        expect_v("x7_after_busy", 2, 64'h0);
        expect_v("x7_after_stall", 3, 64'h0);
        sample();

        // WAW on x3; an issue during stall is dropped
        set_ra(5'd0, 5'd0);
        ie = 1'b1; ird = 5'd3;
        tick();
        expect_v("x3_waw_stall", 3, 64'h1);
        sample();
        ird = 5'd4;
        set_ra(5'd3, 5'd0);
        expect_v("x3_raw_busy", 2, 64'h1);
        expect_v("x3_raw_stall", 3, 64'h1);
        sample();
        tick();
        ie = 1'b0;
        set_ra(5'd4, 5'd3);
        expect_v("x4_dropped_busy", 2, 64'h2);
        expect_v("x4_dropped_stall", 3, 64'h1);
        sample();
        set_ra(5'd0, 5'd0);
        we = 1'b1; wr = 5'd3; wdata = 32'h33;
        tick();
        we = 1'b0;
        ie = 1'b1; ird = 5'd3;
        expect_v("x3_reissue_stall", 3, 64'h0);
        sample();
        tick();
        ie = 1'b0;
        set_ra(5'd3, 5'd0);
        expect_v("x3_reissue_busy", 2, 64'h1);
        expect_v("x3_reissue_rd", 0, 64'h33);
        sample();
        we = 1'b1; wr = 5'd3; wdata = 32'h44;
        tick();
        we = 1'b0;
        expect_v("x3_cleared_busy", 2, 64'h0);
        expect_v("x3_cleared_rd", 0, 64'h44);
        sample();

        // Same-edge write and issue on x9: issue wins
        set_ra(5'd0, 5'd0);
        we = 1'b1; wr = 5'd9; wdata = 32'h1;
        ie = 1'b1; ird = 5'd9;
        expect_v("x9_same_stall", 3, 64'h0);
        sample();
        tick();
        we = 1'b0; ie = 1'b0;
        set_ra(5'd0, 5'd9);
        expect_v("x9_rd", 1, 64'h1);
        expect_v("x9_busy", 2, 64'h2);
        expect_v("x9_stall", 3, 64'h1);
        sample();
        we = 1'b1; wr = 5'd9; wdata = 32'h1;
        tick();
        we = 1'b0;

        // Reset mid-run drops pending state
        ie = 1'b1; ird = 5'd10;
        tick();
        ie = 1'b0;
        set_ra(5'd10, 5'd9);
        expect_v("x10_busy", 2, 64'h1);
        expect_v("x10_stall", 3, 64'h1);
        expect_v("x9_pre_rst", 1, 64'h1);
        sample();
        rst_n = 1'b0;
        expect_v("midrst_busy", 2, 64'h0);
        expect_v("midrst_stall", 3, 64'h0);
        expect_v("midrst_rd1", 1, 64'h0);
        sample();
        rst_n = 1'b1;
        tick();

        // Wide three-port instance
        we3 = 1'b1; wr3 = 4'd15; wdata3 = 64'hFFFF_0000_FFFF_0000;
        tick();
        we3 = 1'b0;
        ra3 = {4'd15, 4'd15, 4'd15};
        expect_v("w3_p0", 4, 64'hFFFF_0000_FFFF_0000);
        expect_v("w3_p1", 5, 64'hFFFF_0000_FFFF_0000);
        expect_v("w3_p2", 6, 64'hFFFF_0000_FFFF_0000);
        expect_v("w3_busy", 7, 64'h0);
        sample();
        ra3 = {4'd0, 4'd15, 4'd2};
        expect_v("w3_p0_x2", 4, 64'h0);
        expect_v("w3_p1_x15", 5, 64'hFFFF_0000_FFFF_0000);
        expect_v("w3_p2_x0", 6, 64'h0);
        sample();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
